poly_oscillator: RTL and testbench

Multi-voice, single-clock phase-accumulator oscillator that generates one saw/square/triangle sample per voice at a programmable sample rate, plus a registered mix of all voices. It is the parametrised successor of the single-voice clock-divider oscillator: no derived clocks, a per-voice octave shift, waveform select and runtime-programmable pitch. It sits between the key/voice allocator (config writes) and the PWM/DAC output stage (samples + strobe).

---
 rtl/poly_oscillator.sv | 141 ++++++++++++++
 tb/tb_poly_oscillator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_oscillator.sv
// Multi-voice phase-accumulator oscillator: per-voice saw/square/triangle samples
// and their registered sum, refreshed once every SAMPLE_DIV clock cycles.
module poly_oscillator #(
    parameter int VOICES     = 4,
    parameter int PHASE_W    = 16,
    parameter int OUT_W      = 8,
    parameter int SAMPLE_DIV = 149,
    localparam int VW        = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int MW        = OUT_W + $clog2(VOICES)
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [VW-1:0]           wr_voice,
    input  logic [PHASE_W-1:0]      wr_inc,
    input  logic [1:0]              wr_octave,
    input  logic [1:0]              wr_wave,
    input  logic                    wr_sync,
    output logic [VOICES*OUT_W-1:0] sample,
    output logic [MW-1:0]           mix,
    output logic                    sample_valid
);

    localparam int PW = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_e;

    logic [PW-1:0]             presc_q, presc_d;
    logic                      tick;
    logic                      tick_q, tick_d;
    logic [PHASE_W-1:0]        phase_q [VOICES];
    logic [PHASE_W-1:0]        phase_d [VOICES];
    logic [PHASE_W-1:0]        inc_q   [VOICES];
    logic [PHASE_W-1:0]        inc_d   [VOICES];
    logic [1:0]                oct_q   [VOICES];
    logic [1:0]                oct_d   [VOICES];
    wave_e                     wave_q  [VOICES];
    wave_e                     wave_d  [VOICES];
    logic [VOICES*OUT_W-1:0]   sample_q, sample_d;
    logic [MW-1:0]             mix_q, mix_d;
    logic                      valid_q, valid_d;
    logic [VOICES*OUT_W-1:0]   shaped;
    logic [MW-1:0]             mix_sum;

    function automatic logic [OUT_W-1:0] shape(input logic [PHASE_W-1:0] p, input wave_e w);
        logic [OUT_W-1:0] t;
        logic [OUT_W-1:0] u;
        t = p[PHASE_W-1 -: OUT_W];
        u = p[PHASE_W-2 -: OUT_W];
        case (w)
            WAVE_SAW:    shape = t;
            WAVE_SQUARE: shape = p[PHASE_W-1] ? '1 : '0;
            WAVE_TRI:    shape = p[PHASE_W-1] ? ~u : u;
            default:     shape = '0;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        tick   = enable && (presc_q == PW'(SAMPLE_DIV - 1));
        tick_d = tick;
        if (!enable || tick) presc_d = '0;
        else                 presc_d = presc_q + PW'(1);

        // A tick always advances from the old config; a synced write wins over the tick.
        for (int v = 0; v < VOICES; v++) begin
            inc_d[v]   = inc_q[v];
            oct_d[v]   = oct_q[v];
            wave_d[v]  = wave_q[v];
            phase_d[v] = phase_q[v];
            if (tick) phase_d[v] = phase_q[v] + (inc_q[v] >> oct_q[v]);
            if (wr_en && (wr_voice == VW'(v))) begin
                inc_d[v]  = wr_inc;
                oct_d[v]  = wr_octave;
                wave_d[v] = wave_e'(wr_wave);
                if (wr_sync) phase_d[v] = '0;
            end
            if (!enable) phase_d[v] = '0;
        end

        shaped  = '0;
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++) begin
            shaped[v*OUT_W +: OUT_W] = shape(phase_q[v], wave_q[v]);
            mix_sum = mix_sum + MW'(shaped[v*OUT_W +: OUT_W]);
        end

        sample_d = sample_q;
        mix_d    = mix_q;
        valid_d  = 1'b0;
        if (!enable) begin
            sample_d = '0;
            mix_d    = '0;
        end else if (tick_q) begin
            sample_d = shaped;
            mix_d    = mix_sum;
            valid_d  = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the config arrays are reset too, since a voice must come up silent.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            sample_q <= '0;
            mix_q    <= '0;
            valid_q  <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
                oct_q[v]   <= '0;
                wave_q[v]  <= WAVE_SILENT;
            end
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            sample_q <= sample_d;
            mix_q    <= mix_d;
            valid_q  <= valid_d;
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                inc_q[v]   <= inc_d[v];
                oct_q[v]   <= oct_d[v];
                wave_q[v]  <= wave_d[v];
            end
        end
    end

    assign sample       = sample_q;
    assign mix          = mix_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_poly_oscillator.sv
// Self-checking bench for poly_oscillator: table-driven waveform vectors with a
// strobe-driven scoreboard, plus sequences for sync, wrap, enable and reset corners.
module tb_poly_oscillator;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        nRst, enable;
    logic        wr_en, wr_sync;
    logic [1:0]  wr_voice, wr_octave, wr_wave;
    logic [15:0] wr_inc;
    logic [31:0] sample;
    logic [9:0]  mix;
    logic        sample_valid;

    logic        wr3_en, wr3_sync;
    logic [1:0]  wr3_voice, wr3_octave, wr3_wave;
    logic [15:0] wr3_inc;
    logic [23:0] sample3;
    logic [9:0]  mix3;
    logic        valid3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_oscillator #(.VOICES(4), .PHASE_W(16), .OUT_W(8), .SAMPLE_DIV(D)) dut (
        .clk(clk), .nRst(nRst), .enable(enable),
        .wr_en(wr_en), .wr_voice(wr_voice), .wr_inc(wr_inc), .wr_octave(wr_octave),
        .wr_wave(wr_wave), .wr_sync(wr_sync),
        .sample(sample), .mix(mix), .sample_valid(sample_valid)
    );

    poly_oscillator #(.VOICES(3), .PHASE_W(16), .OUT_W(8), .SAMPLE_DIV(D)) dut3 (
        .clk(clk), .nRst(nRst), .enable(enable),
        .wr_en(wr3_en), .wr_voice(wr3_voice), .wr_inc(wr3_inc), .wr_octave(wr3_octave),
        .wr_wave(wr3_wave), .wr_sync(wr3_sync),
        .sample(sample3), .mix(mix3), .sample_valid(valid3)
    );

    typedef struct packed {
        logic [31:0] s;
        logic [9:0]  m;
    } exp_t;

    typedef struct packed {
        logic [3:0][15:0] inc;
        logic [3:0][1:0]  oct;
        logic [3:0][1:0]  wave;
        logic [3:0][31:0] s;
        logic [3:0][9:0]  m;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sample_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sample", sample, e.s);
            check("mix", 32'(mix), 32'(e.m));
        end
    end

    // Counts negedges until a strobe is seen; gives up after 40.
    task automatic wait_strobe(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sample_valid === 1'b1) break;
        end
    endtask

    task automatic set_enable(input logic e);
        @(posedge clk);
        #1 enable = e;
    endtask

    task automatic do_write(input int v, input logic [15:0] inc, input logic [1:0] oct,
                            input logic [1:0] wave, input logic sync);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_voice = 2'(v); wr_inc = inc; wr_octave = oct; wr_wave = wave; wr_sync = sync;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_sync = 1'b0;
    endtask

    task automatic do_write3(input int v, input logic [15:0] inc, input logic [1:0] wave,
                             input logic sync);
        @(posedge clk);
        #1;
        wr3_en = 1'b1; wr3_voice = 2'(v); wr3_inc = inc; wr3_octave = 2'd0; wr3_wave = wave; wr3_sync = sync;
        @(posedge clk);
        #1;
        wr3_en = 1'b0; wr3_sync = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic [9:0] m);
        exp_t e;
        e.s = s;
        e.m = m;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        // Strobe order in s/m is {4th, 3rd, 2nd, 1st}; voice order is {v3, v2, v1, v0}.
        vecs[0] = '{inc: {16'h0, 16'h0, 16'h0, 16'h0100}, oct: '0, wave: {2'd3, 2'd3, 2'd3, 2'd0},
                    s: {32'h04, 32'h03, 32'h02, 32'h01}, m: {10'h4, 10'h3, 10'h2, 10'h1}};
        vecs[1] = '{inc: {16'h0, 16'h0, 16'h0, 16'h0100}, oct: {2'd0, 2'd0, 2'd0, 2'd2},
                    wave: {2'd3, 2'd3, 2'd3, 2'd0},
                    s: {32'h01, 32'h00, 32'h00, 32'h00}, m: {10'h1, 10'h0, 10'h0, 10'h0}};
        vecs[2] = '{inc: {16'h0, 16'h0, 16'h4000, 16'h0}, oct: '0, wave: {2'd3, 2'd3, 2'd1, 2'd3},
                    s: {32'h0000, 32'hFF00, 32'hFF00, 32'h0000}, m: {10'h0, 10'hFF, 10'hFF, 10'h0}};
        vecs[3] = '{inc: {16'h0, 16'h0, 16'h4000, 16'h0}, oct: '0, wave: {2'd3, 2'd3, 2'd2, 2'd3},
                    s: {32'h0000, 32'h7F00, 32'hFF00, 32'h8000}, m: {10'h0, 10'h7F, 10'hFF, 10'h80}};
        vecs[4] = '{inc: {16'h0, 16'h0, 16'h2000, 16'h1000}, oct: '0, wave: {2'd3, 2'd3, 2'd0, 2'd0},
                    s: {32'h8040, 32'h6030, 32'h4020, 32'h2010}, m: {10'hC0, 10'h90, 10'h60, 10'h30}};
        vecs[5] = '{inc: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, oct: '0,
                    wave: {2'd1, 2'd1, 2'd1, 2'd1},
                    s: {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF}, m: {10'h0, 10'h3FC, 10'h0, 10'h3FC}};
        vecs[6] = '{inc: {16'hFFFF, 16'h4000, 16'h0, 16'h0}, oct: {2'd1, 2'd3, 2'd0, 2'd0},
                    wave: {2'd0, 2'd2, 2'd3, 2'd3},
                    s: {32'hFF40_0000, 32'h7F30_0000, 32'hFF20_0000, 32'h7F10_0000},
                    m: {10'h13F, 10'h0AF, 10'h11F, 10'h08F}};
        vecs[7] = '{inc: {16'h0, 16'h0, 16'h0, 16'h1000}, oct: '0, wave: {2'd3, 2'd3, 2'd3, 2'd3},
                    s: '0, m: '0};

        nRst = 1'b0; enable = 1'b0;
        wr_en = 1'b0; wr_sync = 1'b0; wr_voice = '0; wr_inc = '0; wr_octave = '0; wr_wave = '0;
        wr3_en = 1'b0; wr3_sync = 1'b0; wr3_voice = '0; wr3_inc = '0; wr3_octave = '0; wr3_wave = '0;
        #12;
        check("reset sample", sample, 32'h0);
        check("reset mix", 32'(mix), 32'h0);
        check("reset valid", 32'(sample_valid), 32'h0);
        @(posedge clk);
        #1 nRst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_enable(1'b0);
            for (int v = 0; v < 4; v++)
                do_write(v, vecs[i].inc[v], vecs[i].oct[v], vecs[i].wave[v], 1'b0);
            for (int k = 0; k < 4; k++) sb_q.push_back(mk(vecs[i].s[k], vecs[i].m[k]));
            set_enable(1'b1);
            for (int k = 0; k < 4; k++) begin
                wait_strobe(cyc);
                check($sformatf("vec%0d strobe%0d spacing", i, k), cyc, (k == 0) ? D + 2 : D);
            end
            #1 check($sformatf("vec%0d drained", i), sb_q.size(), 0);
        end

        // Saw wraps to 0x00 on the 256th strobe.
        set_enable(1'b0);
        do_write(0, 16'h0100, 2'd0, 2'd0, 1'b0);
        for (int v = 1; v < 4; v++) do_write(v, 16'h0, 2'd0, 2'd3, 1'b0);
        for (int k = 1; k <= 257; k++) sb_q.push_back(mk(32'(k % 256), 10'(k % 256)));
        set_enable(1'b1);
        for (int k = 0; k < 257; k++) begin
            wait_strobe(cyc);
            if (k == 0 || k == 255) check("wrap spacing", cyc, (k == 0) ? D + 2 : D);
        end
        #1 check("wrap drained", sb_q.size(), 0);

        // Synced write on a tick edge, then an unsynced one.
        set_enable(1'b0);
        do_write(0, 16'h1000, 2'd0, 2'd0, 1'b0);
        do_write(1, 16'h1000, 2'd0, 2'd0, 1'b0);
        do_write(2, 16'h0, 2'd0, 2'd3, 1'b0);
        do_write(3, 16'h0, 2'd0, 2'd3, 1'b0);
        sb_q.push_back(mk(32'h1010, 10'h20));
        sb_q.push_back(mk(32'h2020, 10'h40));
        set_enable(1'b1);
        wait_strobe(cyc);
        wait_strobe(cyc);
        sb_q.push_back(mk(32'h3000, 10'h30));
        sb_q.push_back(mk(32'h4002, 10'h42));
        @(posedge clk);
        do_write(0, 16'h0200, 2'd0, 2'd0, 1'b1);
        wait_strobe(cyc);
        wait_strobe(cyc);
        sb_q.push_back(mk(32'h5004, 10'h54));
        sb_q.push_back(mk(32'h5106, 10'h57));
        @(posedge clk);
        do_write(1, 16'h0100, 2'd0, 2'd0, 1'b0);
        wait_strobe(cyc);
        wait_strobe(cyc);
        check("sync period", cyc, D);
        #1 check("sync drained", sb_q.size(), 0);

        // Enable drops right after a tick edge: the pending update is discarded.
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check("hold between strobes", sample, 32'h5106);
        @(negedge clk);
        check("disable valid", 32'(sample_valid), 32'h0);
        check("disable sample", sample, 32'h0);
        check("disable mix", 32'(mix), 32'h0);
        sb_q.push_back(mk(32'h0102, 10'h003));
        set_enable(1'b1);
        wait_strobe(cyc);
        check("reenable first strobe", cyc, D + 2);
        #1 check("retain drained", sb_q.size(), 0);

        // Asynchronous reset mid-run restores silent config.
        wait_strobe(cyc);
        nRst = 1'b0;
        #1;
        check("async rst valid", 32'(sample_valid), 32'h0);
        check("async rst sample", sample, 32'h0);
        check("async rst mix", 32'(mix), 32'h0);
        @(posedge clk);
        #1 nRst = 1'b1;
        sb_q.push_back(mk(32'h0, 10'h0));
        wait_strobe(cyc);
        check("post rst first strobe", cyc, D + 2);
        #1 check("rst drained", sb_q.size(), 0);

        // Out-of-range voice index on a 3-voice instance is ignored.
        do_write3(3, 16'h1000, 2'd0, 1'b1);
        wait_strobe(cyc);
        wait_strobe(cyc);
        check("bad voice sample", 32'(sample3), 32'h0);
        check("bad voice mix", 32'(mix3), 32'h0);
        do_write3(2, 16'h1000, 2'd0, 1'b0);
        wait_strobe(cyc);
        check("v3 valid", 32'(valid3), 32'h1);
        check("v3 sample", 32'(sample3), 32'h0010_0000);
        check("v3 mix", 32'(mix3), 32'h010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
